// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage RAW scheduler.
package decode_hazard_ctrl_pkg;

  localparam int REG_SEL_W      = 3;
  localparam int NUM_REGS       = 8;
  localparam int WB_LAT_DEFAULT = 3;
  localparam logic [REG_SEL_W-1:0] LINK_REG = 3'b111;

  typedef struct packed {
    logic                 v;
    logic [REG_SEL_W-1:0] sel;
  } sb_entry_t;

endpackage

// File: rtl/decode_hazard_ctrl_hazard_cmp.sv
// Matches one decode source register against the in-flight scoreboard entries.
module hazard_cmp
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [REG_SEL_W-1:0] src_sel,
  input  logic                 src_used,
  input  sb_entry_t [N-1:0]    entries,
  output logic                 match
);

  logic [N-1:0] hit;

  for (genvar gi = 0; gi < N; gi++) begin : g_cmp
    assign hit[gi] = entries[gi].v && (entries[gi].sel == src_sel);
  end

  assign match = src_used & (|hit);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode RAW scheduler: shift-register scoreboard of pending writes, stall/issue
// generation, wrong-path kill on flush and a saturating stall-cycle counter.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int WB_LAT      = WB_LAT_DEFAULT,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_SEL_W-1:0] id_rs_sel,
  input  logic                 id_rs_used,
  input  logic [REG_SEL_W-1:0] id_rt_sel,
  input  logic                 id_rt_used,
  input  logic                 id_wr_en,
  input  logic [REG_SEL_W-1:0] id_wr_sel,
  input  logic                 flush,
  input  logic                 hold,
  output logic                 stall,
  output logic                 issue,
  output logic [NUM_REGS-1:0]  pend_mask,
  output logic [CNT_W-1:0]     stall_cnt
);

  sb_entry_t [WB_LAT-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rs_hit, rt_hit, hazard, hazard_stall;

  // The oldest entry writes back this cycle and is bypassed, so it is excluded.
  hazard_cmp #(.N(WB_LAT-1)) u_cmp_rs (
    .src_sel  (id_rs_sel),
    .src_used (id_rs_used),
    .entries  (sb_q[WB_LAT-2:0]),
    .match    (rs_hit)
  );

  hazard_cmp #(.N(WB_LAT-1)) u_cmp_rt (
    .src_sel  (id_rt_sel),
    .src_used (id_rt_used),
    .entries  (sb_q[WB_LAT-2:0]),
    .match    (rt_hit)
  );

  assign hazard       = rs_hit | rt_hit;
  assign hazard_stall = id_valid & hazard & ~flush & ~hold;
  assign stall        = rst & ((id_valid & hazard & ~flush) | hold);
  assign issue        = rst & id_valid & ~hazard & ~flush & ~hold;
  assign stall_cnt    = cnt_q;

  always_comb begin
    pend_mask = '0;
    for (int k = 0; k < WB_LAT-1; k++) begin
      if (sb_q[k].v) pend_mask[sb_q[k].sel] = 1'b1;
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (!hold) begin
      sb_d[0].v   = issue & id_wr_en;
      sb_d[0].sel = id_wr_sel;
      for (int k = 1; k < WB_LAT; k++) sb_d[k] = sb_q[k-1];
      if (flush) begin
        for (int k = 0; k < FLUSH_DEPTH; k++) sb_d[k].v = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard_stall && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed vector bench for decode_hazard_ctrl: a cycle-by-cycle table plus
// hand sequences for async reset, counter saturation and deeper flush.
module tb_decode_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, flush, hold;
  logic [2:0] id_rs_sel, id_rt_sel, id_wr_sel;
  logic       stall, issue, stall_a, issue_a;
  logic [7:0] pend_mask, pend_a;
  logic [15:0] stall_cnt;
  logic [3:0]  cnt_a;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.WB_LAT(3), .FLUSH_DEPTH(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_sel(id_rs_sel), .id_rs_used(id_rs_used),
    .id_rt_sel(id_rt_sel), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_sel(id_wr_sel),
    .flush(flush), .hold(hold),
    .stall(stall), .issue(issue), .pend_mask(pend_mask), .stall_cnt(stall_cnt)
  );

  // Narrow counter and deeper flush, to reach saturation and observable flush kill.
  decode_hazard_ctrl #(.WB_LAT(3), .FLUSH_DEPTH(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_sel(id_rs_sel), .id_rs_used(id_rs_used),
    .id_rt_sel(id_rt_sel), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_sel(id_wr_sel),
    .flush(flush), .hold(hold),
    .stall(stall_a), .issue(issue_a), .pend_mask(pend_a), .stall_cnt(cnt_a)
  );

  typedef struct {
    logic       valid;
    logic [2:0] rs;
    logic       rs_u;
    logic [2:0] rt;
    logic       rt_u;
    logic       wr;
    logic [2:0] wsel;
    logic       fl;
    logic       hd;
    logic       e_stall;
    logic       e_issue;
    logic [7:0] e_pend;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic va, input logic [2:0] rs, input logic rsu,
                              input logic [2:0] rt, input logic rtu, input logic wr,
                              input logic [2:0] ws, input logic fl, input logic hd,
                              input logic es, input logic ei, input logic [7:0] ep,
                              input logic [15:0] ec);
    vec_t t;
    t.valid = va; t.rs = rs; t.rs_u = rsu; t.rt = rt; t.rt_u = rtu;
    t.wr = wr; t.wsel = ws; t.fl = fl; t.hd = hd;
    t.e_stall = es; t.e_issue = ei; t.e_pend = ep; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    id_valid = t.valid; id_rs_sel = t.rs; id_rs_used = t.rs_u;
    id_rt_sel = t.rt; id_rt_used = t.rt_u; id_wr_en = t.wr; id_wr_sel = t.wsel;
    flush = t.fl; hold = t.hd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[36];
  vec_t wr_r1, rd_r1, wr_r7, rd_r7_fl, idle;

  initial begin
    // ADD r2,r1,r3 behind ADDI r1
    vecs[0]  = mk(1,0,1,0,0,1,1,0,0, 0,1,8'h00,0);
    vecs[1]  = mk(1,1,1,3,1,1,2,0,0, 1,0,8'h02,0);
    vecs[2]  = mk(1,1,1,3,1,1,2,0,0, 1,0,8'h02,1);
    vecs[3]  = mk(1,1,1,3,1,1,2,0,0, 0,1,8'h00,2);
    // distance 2 and distance 3 readers of r4
    vecs[4]  = mk(1,0,1,0,0,1,4,0,0, 0,1,8'h04,2);
    vecs[5]  = mk(1,6,1,0,0,0,0,0,0, 0,1,8'h14,2);
    vecs[6]  = mk(1,4,1,0,0,0,0,0,0, 1,0,8'h10,2);
    vecs[7]  = mk(1,4,1,0,0,0,0,0,0, 0,1,8'h00,3);
    vecs[8]  = mk(1,0,1,0,0,1,4,0,0, 0,1,8'h00,3);
    vecs[9]  = mk(1,6,1,0,0,0,0,0,0, 0,1,8'h10,3);
    vecs[10] = mk(1,6,1,0,0,0,0,0,0, 0,1,8'h10,3);
    vecs[11] = mk(1,4,1,0,0,0,0,0,0, 0,1,8'h00,3);
    // rt port gated by id_rt_used
    vecs[12] = mk(1,0,1,0,0,1,5,0,0, 0,1,8'h00,3);
    vecs[13] = mk(1,0,1,5,0,0,0,0,0, 0,1,8'h20,3);
    vecs[14] = mk(1,0,1,5,1,0,0,0,0, 1,0,8'h20,3);
    vecs[15] = mk(1,0,1,5,1,0,0,0,0, 0,1,8'h00,4);
    // JAL then flushed reader of r7: JAL stays in entry 1
    vecs[16] = mk(1,0,1,0,0,1,7,0,0, 0,1,8'h00,4);
    vecs[17] = mk(1,7,1,0,0,0,0,1,0, 0,0,8'h80,4);
    vecs[18] = mk(1,0,1,0,0,0,0,0,0, 0,1,8'h80,4);
    vecs[19] = mk(1,0,1,0,0,0,0,0,0, 0,1,8'h00,4);
    // hold freezes scoreboard and counter
    vecs[20] = mk(1,0,1,0,0,1,2,0,0, 0,1,8'h00,4);
    vecs[21] = mk(1,2,1,0,0,0,0,0,1, 1,0,8'h04,4);
    vecs[22] = mk(1,2,1,0,0,0,0,0,1, 1,0,8'h04,4);
    vecs[23] = mk(1,2,1,0,0,0,0,0,1, 1,0,8'h04,4);
    vecs[24] = mk(1,2,1,0,0,0,0,0,0, 1,0,8'h04,4);
    vecs[25] = mk(1,2,1,0,0,0,0,0,0, 1,0,8'h04,5);
    vecs[26] = mk(1,2,1,0,0,0,0,0,0, 0,1,8'h00,6);
    // flush under hold is ignored, then honoured
    vecs[27] = mk(1,0,1,0,0,1,3,0,0, 0,1,8'h00,6);
    vecs[28] = mk(1,3,1,0,0,0,0,1,1, 1,0,8'h08,6);
    vecs[29] = mk(1,3,1,0,0,0,0,1,0, 0,0,8'h08,6);
    vecs[30] = mk(0,3,1,0,0,0,0,0,0, 0,0,8'h08,6);
    vecs[31] = mk(0,3,1,0,0,0,0,0,0, 0,0,8'h00,6);
    // self-dependency does not stall, later reader does
    vecs[32] = mk(1,1,1,1,1,1,1,0,0, 0,1,8'h00,6);
    vecs[33] = mk(1,1,1,0,0,0,0,0,0, 1,0,8'h02,6);
    vecs[34] = mk(1,1,1,0,0,0,0,0,0, 1,0,8'h02,7);
    vecs[35] = mk(1,1,1,0,0,0,0,0,0, 0,1,8'h00,8);

    idle     = mk(0,0,0,0,0,0,0,0,0, 0,0,8'h00,0);
    wr_r1    = mk(1,0,1,0,0,1,1,0,0, 0,0,8'h00,0);
    rd_r1    = mk(1,1,1,0,0,0,0,0,0, 0,0,8'h00,0);
    wr_r7    = mk(1,0,1,0,0,1,7,0,0, 0,0,8'h00,0);
    rd_r7_fl = mk(1,7,1,0,0,0,0,1,0, 0,0,8'h00,0);

    // reset state, with a valid instruction presented
    rst = 1'b0;
    apply(vecs[0]);
    #2;
    chk("rst_stall", 0, {31'd0, stall}, 32'd0);
    chk("rst_issue", 0, {31'd0, issue}, 32'd0);
    chk("rst_pend",  0, {24'd0, pend_mask}, 32'd0);
    chk("rst_cnt",   0, {16'd0, stall_cnt}, 32'd0);
    step();
    step();
    rst = 1'b1;

    for (int i = 0; i < 36; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      $display("vec %0d: stall=%0b issue=%0b pend=%02h cnt=%0d", i, stall, issue,
               pend_mask, stall_cnt);
      chk("stall", i, {31'd0, stall}, {31'd0, vecs[i].e_stall});
      chk("issue", i, {31'd0, issue}, {31'd0, vecs[i].e_issue});
      chk("pend",  i, {24'd0, pend_mask}, {24'd0, vecs[i].e_pend});
      chk("cnt",   i, {16'd0, stall_cnt}, {16'd0, vecs[i].e_cnt});
      step();
    end

    // asynchronous reset mid-stall with r1 and r6 pending
    apply(wr_r1); step();
    apply(mk(1,0,1,0,0,1,6,0,0, 0,0,8'h00,0)); step();
    apply(rd_r1);
    @(negedge clk);
    chk("pre_rst_pend",  0, {24'd0, pend_mask}, 32'h42);
    chk("pre_rst_stall", 0, {31'd0, stall}, 32'd1);
    chk("pre_rst_cnt",   0, {16'd0, stall_cnt}, 32'd8);
    #1 rst = 1'b0;
    #1;
    $display("async rst: pend=%02h cnt=%0d stall=%0b", pend_mask, stall_cnt, stall);
    chk("arst_pend",  0, {24'd0, pend_mask}, 32'd0);
    chk("arst_cnt",   0, {16'd0, stall_cnt}, 32'd0);
    chk("arst_stall", 0, {31'd0, stall}, 32'd0);
    chk("arst_issue", 0, {31'd0, issue}, 32'd0);
    apply(idle);
    step();
    rst = 1'b1;

    // 10 writer/reader pairs: 20 hazard cycles, narrow counter pins at 15
    for (int r = 0; r < 10; r++) begin
      apply(wr_r1); step();
      apply(rd_r1); step(); step(); step();
    end
    apply(idle);
    @(negedge clk);
    $display("saturation: cnt=%0d cnt_a=%0d", stall_cnt, cnt_a);
    chk("sat_cnt_wide", 0, {16'd0, stall_cnt}, 32'd20);
    chk("sat_cnt_narrow", 0, {28'd0, cnt_a}, 32'd15);
    step();

    // flush kills entry 1 only when FLUSH_DEPTH covers it
    apply(wr_r7); step();
    apply(rd_r7_fl);
    @(negedge clk);
    chk("fl_stall", 0, {31'd0, stall_a}, 32'd0);
    chk("fl_issue", 0, {31'd0, issue_a}, 32'd0);
    step();
    apply(idle);
    @(negedge clk);
    $display("flush depth: pend=%02h pend_a=%02h", pend_mask, pend_a);
    chk("fl_pend_d1", 0, {24'd0, pend_mask}, 32'h80);
    chk("fl_pend_d2", 0, {24'd0, pend_a}, 32'h00);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
